// File: rtl/fwd_scoreboard_if.sv
// fwd_scoreboard_if: decode-side bundle for the forwarding scoreboard.
//   master : decode / pipeline control (drives issue, flush, stage results,
//            source addresses and register-file data; receives operands,
//            stall request and stall count)
//   slave  : fwd_scoreboard
// Signals:
//   advance      pipeline shifts this cycle (0 = global stall)
//   issue_*      instruction currently in decode (valid, writes, dest, load)
//   flush_mask   bit k kills tracked entry k at the next edge
//   stage_data   result held in each tracked stage, slice k = entry k
//   src_addr     decode source register addresses, slice s = source s
//   rf_rdata     register-file read data for those sources
//   src_data     forwarded operands
//   stall_req    load-use hazard, decode must hold
//   stall_cnt    saturating count of stalled cycles
interface fwd_scoreboard_if #(
    parameter int DEPTH = 3,
    parameter int NSRC  = 2,
    parameter int AW    = 5,
    parameter int DW    = 32
);
    logic                 advance;
    logic                 issue_valid;
    logic                 issue_wen;
    logic [AW-1:0]        issue_waddr;
    logic                 issue_load;
    logic [DEPTH-1:0]     flush_mask;
    logic [DEPTH*DW-1:0]  stage_data;
    logic [NSRC*AW-1:0]   src_addr;
    logic [NSRC*DW-1:0]   rf_rdata;
    logic [NSRC*DW-1:0]   src_data;
    logic                 stall_req;
    logic [31:0]          stall_cnt;

    modport master (
        output advance, issue_valid, issue_wen, issue_waddr, issue_load,
               flush_mask, stage_data, src_addr, rf_rdata,
        input  src_data, stall_req, stall_cnt
    );

    modport slave (
        input  advance, issue_valid, issue_wen, issue_waddr, issue_load,
               flush_mask, stage_data, src_addr, rf_rdata,
        output src_data, stall_req, stall_cnt
    );
endinterface

// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: hazard detection and operand forwarding for decode.
// Tracks {valid, dest, load} for the DEPTH stages after decode (entry 0 = EX,
// entry DEPTH-1 = WB). Every cycle each decode source gets the value of its
// youngest in-flight producer, or the register file when there is none, and a
// load-use stall is requested when that youngest producer is a load whose
// data is not yet available.
// Ports:
//   clk  clock
//   rst  asynchronous active-low reset (clears all entries and stall_cnt)
//   bus  fwd_scoreboard_if slave modport (see interface file)
module fwd_scoreboard #(
    parameter int DEPTH      = 3,
    parameter int NSRC       = 2,
    parameter int AW         = 5,
    parameter int DW         = 32,
    parameter int LOAD_STAGE = 1
) (
    input  logic            clk,
    input  logic            rst,
    fwd_scoreboard_if.slave bus
);
    logic          valid_reg [DEPTH];
    logic [AW-1:0] waddr_reg [DEPTH];
    logic          load_reg  [DEPTH];
    logic [31:0]   stall_cnt_reg;

    logic [NSRC-1:0] src_stall;
    logic            stall_any;
    logic            issue_ok;

    // Per-source youngest-producer search.
    genvar gi;
    generate
        for (gi = 0; gi < NSRC; gi++) begin : g_src
            logic [AW-1:0] addr;
            logic          hit;
            logic          ready;
            logic [DW-1:0] fwd;

            assign addr = bus.src_addr[gi*AW +: AW];

            // Walk from oldest to youngest so the youngest match is the last
            // one written and therefore wins. A not-ready winner falls back
            // to the register-file value so the output stays deterministic.
            always_comb begin
                hit   = 1'b0;
                ready = 1'b0;
                fwd   = bus.rf_rdata[gi*DW +: DW];
                for (int k = DEPTH - 1; k >= 0; k--) begin
                    if (valid_reg[k] && (waddr_reg[k] != '0) && (waddr_reg[k] == addr)) begin
                        hit   = 1'b1;
                        ready = !load_reg[k] || (k >= LOAD_STAGE);
                        fwd   = ready ? bus.stage_data[k*DW +: DW]
                                      : bus.rf_rdata[gi*DW +: DW];
                    end
                end
            end

            assign bus.src_data[gi*DW +: DW] = fwd;
            assign src_stall[gi]             = hit & ~ready;
        end
    endgenerate

    assign stall_any     = |src_stall;
    assign bus.stall_req = stall_any;
    assign bus.stall_cnt = stall_cnt_reg;

    // A stalled decode instruction must not enter the pipe; a bubble goes in.
    assign issue_ok = bus.issue_valid & bus.issue_wen & ~stall_any;

    // Entry update: flush is applied first, then either shift or hold.
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            if (gi == 0) begin : g_head
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        valid_reg[0] <= 1'b0;
                        waddr_reg[0] <= '0;
                        load_reg[0]  <= 1'b0;
                    end else if (bus.advance) begin
                        valid_reg[0] <= issue_ok;
                        waddr_reg[0] <= bus.issue_waddr;
                        load_reg[0]  <= bus.issue_load;
                    end else begin
                        valid_reg[0] <= valid_reg[0] & ~bus.flush_mask[0];
                    end
                end
            end else begin : g_body
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        valid_reg[gi] <= 1'b0;
                        waddr_reg[gi] <= '0;
                        load_reg[gi]  <= 1'b0;
                    end else if (bus.advance) begin
                        valid_reg[gi] <= valid_reg[gi-1] & ~bus.flush_mask[gi-1];
                        waddr_reg[gi] <= waddr_reg[gi-1];
                        load_reg[gi]  <= load_reg[gi-1];
                    end else begin
                        valid_reg[gi] <= valid_reg[gi] & ~bus.flush_mask[gi];
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_reg <= '0;
        end else if (stall_any && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end
endmodule

// File: tb/tb_fwd_scoreboard.sv
module tb_fwd_scoreboard;
    localparam int DEPTH      = 3;
    localparam int NSRC       = 2;
    localparam int AW         = 5;
    localparam int DW         = 32;
    localparam int LOAD_STAGE = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fwd_scoreboard_if #(.DEPTH(DEPTH), .NSRC(NSRC), .AW(AW), .DW(DW)) bus ();

    fwd_scoreboard #(
        .DEPTH(DEPTH), .NSRC(NSRC), .AW(AW), .DW(DW), .LOAD_STAGE(LOAD_STAGE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: list of in-flight producers by age (index = stages past decode).
    typedef struct {
        bit          valid;
        bit [AW-1:0] dest;
        bit          is_load;
    } slot_t;

    slot_t       flight [DEPTH];
    logic [31:0] m_cnt;

    task automatic model_clear();
        for (int k = 0; k < DEPTH; k++) begin
            flight[k].valid   = 1'b0;
            flight[k].dest    = '0;
            flight[k].is_load = 1'b0;
        end
        m_cnt = 32'd0;
    endtask

    // Expected operands and stall from the current in-flight list and inputs.
    function automatic void model_eval(output logic [NSRC*DW-1:0] d, output logic st);
        logic [AW-1:0] r;
        bit            found;
        d  = bus.rf_rdata;
        st = 1'b0;
        for (int s = 0; s < NSRC; s++) begin
            r     = bus.src_addr[s*AW +: AW];
            found = 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                if (!found && r != 0 && flight[k].valid && flight[k].dest == r) begin
                    found = 1'b1;
                    if (!flight[k].is_load || k >= LOAD_STAGE)
                        d[s*DW +: DW] = bus.stage_data[k*DW +: DW];
                    else
                        st = 1'b1;
                end
            end
        end
    endfunction

    // One clock edge: DUT and model advance together; returns 1 time unit after the edge.
    task automatic clock_step();
        logic [NSRC*DW-1:0] dd;
        logic               st;
        model_eval(dd, st);
        @(posedge clk);
        if (!rst) begin
            model_clear();
        end else begin
            for (int k = 0; k < DEPTH; k++)
                if (bus.flush_mask[k]) flight[k].valid = 1'b0;
            if (bus.advance) begin
                for (int k = DEPTH - 1; k > 0; k--) flight[k] = flight[k-1];
                flight[0].valid   = bus.issue_valid && bus.issue_wen && !st;
                flight[0].dest    = bus.issue_waddr;
                flight[0].is_load = bus.issue_load;
            end
            if (st && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        end
        #1;
    endtask

    task automatic set_idle();
        bus.advance     = 1'b1;
        bus.issue_valid = 1'b0;
        bus.issue_wen   = 1'b0;
        bus.issue_waddr = '0;
        bus.issue_load  = 1'b0;
        bus.flush_mask  = '0;
    endtask

    task automatic drive_issue(input logic wen, input logic [AW-1:0] a, input logic ld);
        bus.issue_valid = 1'b1;
        bus.issue_wen   = wen;
        bus.issue_waddr = a;
        bus.issue_load  = ld;
    endtask

    task automatic drain();
        set_idle();
        bus.src_addr = '0;
        for (int i = 0; i < DEPTH; i++) clock_step();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        model_clear();
        set_idle();
        bus.src_addr   = {5'd4, 5'd3};
        bus.rf_rdata   = {32'h22, 32'h11};
        bus.stage_data = {32'h3333, 32'h2222, 32'h1111};
        clock_step();
        clock_step();
        #2;
        checks++;
        if (bus.src_data !== {32'h22, 32'h11}) begin
            errors++; $display("FAIL reset_src_data got=%h want=%h", bus.src_data, {32'h22, 32'h11});
        end
        checks++;
        if (bus.stall_req !== 1'b0 || bus.stall_cnt !== 32'd0) begin
            errors++; $display("FAIL reset_stall got=%b/%0d want=0/0", bus.stall_req, bus.stall_cnt);
        end
        #2 rst = 1'b1;
        clock_step();
        clock_step();
        #2;
        checks++;
        if (bus.src_data !== {32'h22, 32'h11} || bus.stall_req !== 1'b0 || bus.stall_cnt !== 32'd0) begin
            errors++; $display("FAIL idle_after_reset got=%h/%b/%0d want=%h/0/0",
                               bus.src_data, bus.stall_req, bus.stall_cnt, {32'h22, 32'h11});
        end
    endtask

    task automatic test_alu_forward();
        logic [DW-1:0] want;
        drain();
        drive_issue(1'b1, 5'd5, 1'b0);
        clock_step();
        set_idle();
        bus.src_addr   = {5'd0, 5'd5};
        bus.rf_rdata   = {32'h0000_0BBB, 32'h0000_0AAA};
        bus.stage_data = {32'h2222_2222, 32'h1111_1111, 32'hDEAD_BEEF};
        for (int hop = 0; hop <= DEPTH; hop++) begin
            #2;
            want = (hop < DEPTH) ? bus.stage_data[hop*DW +: DW] : bus.rf_rdata[DW-1:0];
            checks++;
            if (bus.src_data[DW-1:0] !== want || bus.stall_req !== 1'b0) begin
                errors++; $display("FAIL alu_fwd_hop%0d got=%h/%b want=%h/0",
                                   hop, bus.src_data[DW-1:0], bus.stall_req, want);
            end
            clock_step();
        end
    endtask

    task automatic test_load_use();
        logic [31:0] cnt0;
        drain();
        drive_issue(1'b1, 5'd8, 1'b1);
        clock_step();
        drive_issue(1'b1, 5'd10, 1'b0);
        bus.src_addr   = {5'd8, 5'd0};
        bus.stage_data = {32'h5555_5555, 32'h00C0_FFEE, 32'h7777_7777};
        #2;
        cnt0 = m_cnt;
        checks++;
        if (bus.stall_req !== 1'b1) begin
            errors++; $display("FAIL load_use_stall got=%b want=1", bus.stall_req);
        end
        clock_step();
        #2;
        checks++;
        if (bus.stall_req !== 1'b0 || bus.src_data[DW +: DW] !== 32'h00C0_FFEE) begin
            errors++; $display("FAIL load_use_fwd got=%b/%h want=0/00c0ffee",
                               bus.stall_req, bus.src_data[DW +: DW]);
        end
        checks++;
        if (bus.stall_cnt !== cnt0 + 32'd1) begin
            errors++; $display("FAIL load_use_cnt got=%0d want=%0d", bus.stall_cnt, cnt0 + 32'd1);
        end
        clock_step();
        set_idle();
        bus.src_addr = {5'd10, 5'd0};
        #2;
        checks++;
        if (bus.src_data[DW +: DW] !== bus.stage_data[0 +: DW]) begin
            errors++; $display("FAIL consumer_entered got=%h want=%h",
                               bus.src_data[DW +: DW], bus.stage_data[0 +: DW]);
        end
    endtask

    task automatic test_youngest_wins();
        drain();
        drive_issue(1'b1, 5'd9, 1'b0);
        clock_step();
        clock_step();
        set_idle();
        bus.src_addr   = {5'd9, 5'd9};
        bus.stage_data = {32'h0000_CCCC, 32'h0000_AAAA, 32'h0000_BBBB};
        #2;
        checks++;
        if (bus.src_data !== {32'h0000_BBBB, 32'h0000_BBBB} || bus.stall_req !== 1'b0) begin
            errors++; $display("FAIL youngest_wins got=%h/%b want=0000bbbb0000bbbb/0",
                               bus.src_data, bus.stall_req);
        end
        // Register 0: loads to $0 must neither forward nor stall.
        drive_issue(1'b1, 5'd0, 1'b1);
        for (int i = 0; i < DEPTH; i++) clock_step();
        bus.src_addr = '0;
        bus.rf_rdata = {32'h0000_0002, 32'h0000_0001};
        #2;
        checks++;
        if (bus.src_data !== bus.rf_rdata || bus.stall_req !== 1'b0) begin
            errors++; $display("FAIL reg_zero got=%h/%b want=%h/0",
                               bus.src_data, bus.stall_req, bus.rf_rdata);
        end
    endtask

    task automatic test_global_stall_flush();
        logic [31:0] cnt0;
        drain();
        drive_issue(1'b1, 5'd7, 1'b1);
        clock_step();
        set_idle();
        bus.advance  = 1'b0;
        bus.src_addr = {5'd0, 5'd7};
        bus.rf_rdata = {32'h0000_0044, 32'h0000_0033};
        #2;
        cnt0 = m_cnt;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.stall_req !== 1'b1) begin
                errors++; $display("FAIL global_stall_hold%0d got=%b want=1", i, bus.stall_req);
            end
            clock_step();
            #2;
        end
        checks++;
        if (bus.stall_cnt !== cnt0 + 32'd3) begin
            errors++; $display("FAIL global_stall_cnt got=%0d want=%0d", bus.stall_cnt, cnt0 + 32'd3);
        end
        bus.flush_mask = 3'b001;
        bus.advance    = 1'b1;
        clock_step();
        bus.flush_mask = '0;
        #2;
        checks++;
        if (bus.stall_req !== 1'b0 || bus.src_data[DW-1:0] !== 32'h0000_0033) begin
            errors++; $display("FAIL flush_shift got=%b/%h want=0/00000033",
                               bus.stall_req, bus.src_data[DW-1:0]);
        end
    endtask

    task automatic test_random();
        logic [NSRC*DW-1:0] ed;
        logic               es;
        int                 bad = 0;
        for (int i = 0; i < 400; i++) begin
            bus.advance     = ($urandom_range(0, 5) != 0);
            bus.issue_valid = $urandom_range(0, 1);
            bus.issue_wen   = ($urandom_range(0, 3) != 0);
            bus.issue_waddr = AW'($urandom_range(0, 7));
            bus.issue_load  = ($urandom_range(0, 2) == 0);
            bus.flush_mask  = ($urandom_range(0, 6) == 0) ? DEPTH'($urandom) : '0;
            for (int s = 0; s < NSRC; s++) begin
                bus.src_addr[s*AW +: AW] = AW'($urandom_range(0, 7));
                bus.rf_rdata[s*DW +: DW] = $urandom;
            end
            for (int k = 0; k < DEPTH; k++) bus.stage_data[k*DW +: DW] = $urandom;
            #2;
            model_eval(ed, es);
            checks++;
            if (bus.src_data !== ed || bus.stall_req !== es || bus.stall_cnt !== m_cnt) begin
                errors++;
                if (bad < 10)
                    $display("FAIL random_cycle%0d got=%h/%b/%0d want=%h/%b/%0d", i,
                             bus.src_data, bus.stall_req, bus.stall_cnt, ed, es, m_cnt);
                bad++;
            end
            clock_step();
        end
    endtask

    task automatic test_async_reset();
        drain();
        drive_issue(1'b1, 5'd7, 1'b1);
        clock_step();
        set_idle();
        bus.advance  = 1'b0;
        bus.src_addr = {5'd0, 5'd7};
        bus.rf_rdata = {32'h0000_0066, 32'h0000_0055};
        clock_step();
        #2;
        checks++;
        if (bus.stall_req !== 1'b1 || bus.stall_cnt === 32'd0) begin
            errors++; $display("FAIL pre_async_stall got=%b/%0d want=1/nonzero", bus.stall_req, bus.stall_cnt);
        end
        rst = 1'b0;
        model_clear();
        #1;
        checks++;
        if (bus.stall_req !== 1'b0 || bus.stall_cnt !== 32'd0 || bus.src_data !== bus.rf_rdata) begin
            errors++; $display("FAIL async_reset got=%b/%0d/%h want=0/0/%h",
                               bus.stall_req, bus.stall_cnt, bus.src_data, bus.rf_rdata);
        end
        #2 rst = 1'b1;
        bus.advance = 1'b1;
        drive_issue(1'b1, 5'd7, 1'b1);
        clock_step();
        set_idle();
        #2;
        checks++;
        if (bus.stall_req !== 1'b1 || bus.stall_cnt !== 32'd0) begin
            errors++; $display("FAIL fresh_after_reset got=%b/%0d want=1/0", bus.stall_req, bus.stall_cnt);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        $display("test_reset done: checks=%0d errors=%0d", checks, errors);
        test_alu_forward();
        $display("test_alu_forward done: checks=%0d errors=%0d", checks, errors);
        test_load_use();
        $display("test_load_use done: checks=%0d errors=%0d", checks, errors);
        test_youngest_wins();
        $display("test_youngest_wins done: checks=%0d errors=%0d", checks, errors);
        test_global_stall_flush();
        $display("test_global_stall_flush done: checks=%0d errors=%0d", checks, errors);
        test_random();
        $display("test_random done: checks=%0d errors=%0d", checks, errors);
        test_async_reset();
        $display("test_async_reset done: checks=%0d errors=%0d", checks, errors);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fwd_scoreboard.md
# fwd_scoreboard

Parametrised hazard-detection and operand-forwarding unit for the in-order MIPS pipeline. It replaces the fixed per-stage forwarding buses into decode with one tracking structure. It keeps a shift register of in-flight destination registers for the DEPTH stages after decode. Each cycle it returns the newest value for every decode source operand, and it raises a load-use stall request to the stall controller.

## Interface
Parameters:
- DEPTH, 3, number of tracked post-decode stages; entry 0 = EX, entry DEPTH-1 = WB.
- NSRC, 2, number of decode source operands.
- AW, 5, register address width.
- DW, 32, data width.
- LOAD_STAGE, 1, first entry index at which load data is valid (1 = MEM with synchronous data SRAM); range 0..DEPTH-1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- advance  in  1  pipeline shifts this cycle; 0 = global stall from the stall controller, all entries hold.
- issue_valid  in  1  decode has a valid instruction.
- issue_wen  in  1  that instruction writes a register.
- issue_waddr  in  AW  its destination.
- issue_load  in  1  it is a load.
- flush_mask  in  DEPTH  bit k kills entry k at the next edge.
- stage_data  in  DEPTH*DW  result currently held in each stage; slice k = entry k.
- src_addr  in  NSRC*AW  decode source addresses.
- rf_rdata  in  NSRC*DW  register-file read data for those sources.
- src_data  out  NSRC*DW  forwarded operands.
- stall_req  out  1  load-use hazard; decode must hold.
- stall_cnt  out  32  saturating count of cycles with stall_req=1.

## Operation
- Each entry k holds {valid, waddr, load}.
- An entry counts as writing only if valid=1 and waddr!=0. Register 0 never matches and never stalls.
- Match for source s at entry k: a writing entry with waddr == src_addr[s].
- Winner for source s: the matching entry with the lowest k, i.e. the youngest.
- Winner ready: load=0, or k >= LOAD_STAGE.
- src_data[s]:
  - no match → rf_rdata[s];
  - winner ready → stage_data[winner];
  - winner not ready → rf_rdata[s] (don't-care, but deterministic).
- stall_req = OR over s of (a match exists and the winner is not ready).
- Sequential update, in this order:
  1. Apply flush_mask: each masked entry becomes invalid.
  2. If advance=1:
     - entry k+1 ← (post-flush) entry k;
     - entry 0 ← {issue_valid & issue_wen & ~stall_req, issue_waddr, issue_load};
     - a stalled issue inserts a bubble.
  3. If advance=0: entries hold their post-flush values.
- The oldest entry is dropped on shift; the register file write occurs at that same edge.
- stall_cnt increments each cycle stall_req=1 and saturates at 0xFFFFFFFF.

## Timing
- Entries and stall_cnt are registered. src_data and stall_req are combinational from entries, src_addr, stage_data and rf_rdata, with no input-to-output dependency on issue_* or advance.
- While rst=0 (asynchronous): all entries invalid and stall_cnt=0. Therefore stall_req=0 and src_data=rf_rdata.
- Forward latency is 0 cycles: a result is visible to decode in the same cycle its producer occupies a tracked stage.
- Load-use with LOAD_STAGE=1: a consumer immediately after a load stalls exactly 1 cycle.
- Simultaneous events:
  - flush and advance in the same cycle: flush first, then shift.
  - flush and advance=0: kill in place.
  - stall_req=1 and advance=0: hold, no bubble inserted.
- Duplicate matches: the youngest always wins; older stale values are never selected.
- Reset mid-operation: clears everything immediately. The first edge after release behaves as a fresh pipeline.

## Test plan
- Reset then idle (advance=1, issue_valid=0, src_addr={3,4}, rf_rdata={0x11,0x22}) → src_data={0x11,0x22}, stall_req=0, stall_cnt=0.
- ALU back-to-back: issue addu $5 (non-load), advance; then src_addr[0]=5, stage_data[0]=0xDEADBEEF → src_data[0]=0xDEADBEEF, stall_req=0. After 2 more advances, forwarding comes from slice 2; after 3 advances, src_data[0]=rf_rdata[0].
- Load-use: issue lw $8, advance; src_addr[1]=8 → stall_req=1 for 1 cycle; stall_cnt=1. The next edge inserts a bubble. Then src_data[1]=stage_data[1]=0x00C0FFEE, stall_req=0.
- Youngest wins: issue $9 with value 0xAAAA in entry 1 and $9 with value 0xBBBB in entry 0 → src_data=0xBBBB. Writes to $0 in all entries with src_addr=0 → src_data=rf_rdata, stall_req=0.
- Global stall/flush: load $7 in entry 0, advance=0 for 3 cycles → stall_req stays 1 and stall_cnt=3. Then flush_mask=001 with advance=1 → entry 1 invalid, stall_req=0.
- Async reset asserted mid-stall (rst=0 between edges) → stall_req=0 and stall_cnt=0 immediately, without waiting for a clock edge.
